// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch front end.
package inst_fetch_queue_pkg;

  localparam int unsigned InstW = 32;
  localparam logic [InstW-1:0] NopInst = 32'h0000_0013;  // addi x0, x0, 0
  localparam int unsigned PcStep = 4;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// ROM request/response bus, redirect and ID-side handshake of the fetch front end.
interface inst_fetch_queue_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            rom_ce_o;
  logic [XLEN-1:0] rom_addr_o;
  logic [XLEN-1:0] rom_data_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            inst_valid_o;
  logic [XLEN-1:0] inst_o;
  logic [XLEN-1:0] inst_addr_o;
  logic            inst_ready_i;

  modport master (
    output rom_ce_o, rom_addr_o, inst_valid_o, inst_o, inst_addr_o,
    input  rom_data_i, redirect_i, redirect_pc_i, inst_ready_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, inst_valid_o, inst_o, inst_addr_o,
    output rom_data_i, redirect_i, redirect_pc_i, inst_ready_i
  );

endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// DEPTH-entry prefetch queue of {pc, inst} pairs with push/pop/flush.
module inst_fetch_queue_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_pc_i,
  input  logic [XLEN-1:0] push_inst_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [CntW-1:0] count_o,
  output logic            valid_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_inst_o
);

  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [2*XLEN-1:0] head;
  logic              pop_ok;

  assign pop_ok = pop_i & (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      // Pointers are PtrW wide, so they wrap at DEPTH (a power of two).
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= {push_pc_i, push_inst_i};
  end

  assign head        = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign valid_o     = (count_q != '0);
  assign head_pc_o   = valid_o ? head[2*XLEN-1:XLEN] : '0;
  assign head_inst_o = valid_o ? head[XLEN-1:0] : XLEN'(NopInst);

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: PC generation, credit-based ROM issue, in-flight tag pipe and prefetch queue.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     ROM_LAT  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  inst_fetch_queue_if.master  fetch_if
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [ROM_LAT-1:0] inflight_vld_q, inflight_vld_d;
  logic [XLEN-1:0]    inflight_pc_q [ROM_LAT];
  logic [XLEN-1:0]    inflight_pc_d [ROM_LAT];
  int unsigned        inflight_cnt;
  logic [CntW-1:0]    fifo_count;
  logic               fifo_valid;
  logic               rom_ce;
  logic               push;
  logic               pop;

  always_comb begin
    inflight_cnt = 0;
    for (int unsigned i = 0; i < ROM_LAT; i++) begin
      inflight_cnt += 32'(inflight_vld_q[i]);
    end
  end

  // Credit uses registered occupancy only; a same-cycle pop is not counted.
  assign rom_ce = rst_i & ~fetch_if.redirect_i & ((32'(fifo_count) + inflight_cnt) < DEPTH);

  always_comb begin
    inflight_vld_d[0] = rom_ce;
    inflight_pc_d[0]  = fetch_pc_q;
    for (int unsigned i = 1; i < ROM_LAT; i++) begin
      inflight_vld_d[i] = inflight_vld_q[i-1];
      inflight_pc_d[i]  = inflight_pc_q[i-1];
    end
    if (fetch_if.redirect_i) inflight_vld_d = '0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (fetch_if.redirect_i) begin
      fetch_pc_d = fetch_if.redirect_pc_i;
    end else if (rom_ce) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PcStep);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_q     <= RESET_PC;
      inflight_vld_q <= '0;
      for (int unsigned i = 0; i < ROM_LAT; i++) inflight_pc_q[i] <= '0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      inflight_vld_q <= inflight_vld_d;
      for (int unsigned i = 0; i < ROM_LAT; i++) inflight_pc_q[i] <= inflight_pc_d[i];
    end
  end

  // Responses to requests killed by a redirect are dropped here.
  assign push = inflight_vld_q[ROM_LAT-1] & ~fetch_if.redirect_i;
  assign pop  = fetch_if.inst_ready_i & fifo_valid;

  inst_fetch_queue_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_pc_i   (inflight_pc_q[ROM_LAT-1]),
    .push_inst_i (fetch_if.rom_data_i),
    .pop_i       (pop),
    .flush_i     (fetch_if.redirect_i),
    .count_o     (fifo_count),
    .valid_o     (fifo_valid),
    .head_pc_o   (fetch_if.inst_addr_o),
    .head_inst_o (fetch_if.inst_o)
  );

  assign fetch_if.rom_ce_o     = rom_ce;
  assign fetch_if.rom_addr_o   = fetch_pc_q;
  assign fetch_if.inst_valid_o = fifo_valid;

endmodule
